// File: rtl/audio_capture.sv
// -----------------------------------------------------------------------------
// audio_capture
//
// I2S receive path for the ADC (line-in) side of the Pmod I2S2. It generates
// the ADC master, bit and word clocks from the system clock, deserializes the
// ADC's serial data into signed left/right sample pairs, and raises a
// one-cycle pulse when the left channel's magnitude reaches a loudness
// threshold, so that a clap or knock can be used as a hit source.
//
// Parameters:
//   DATA_W     bits kept per channel, taken MSB-first from the 24-bit word (1..24)
//   THRESHOLD  unsigned magnitude at or above which a loud event fires
//   HOLDOFF    frames after a loud event during which loud events are suppressed
//
// Ports:
//   clk           in   system clock (100 MHz)
//   rst           in   asynchronous active-low reset
//   en_capture    in   capture enable, takes effect at the next frame start
//   audio_sdout   in   ADC serial data (changes on falling edge of adc_sck)
//   adc_mclk      out  ADC master clock, clk/4
//   adc_lrck      out  word select, clk/2048 (0 = left, 1 = right)
//   adc_sck       out  bit clock, clk/32
//   left_sample   out  last complete left sample, two's complement
//   right_sample  out  last complete right sample, two's complement
//   sample_valid  out  one-cycle pulse when both samples update
//   loud_pulse    out  one-cycle pulse coincident with sample_valid
// -----------------------------------------------------------------------------
module audio_capture #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] THRESHOLD = DATA_W'(20000),
    parameter int                HOLDOFF   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_capture,
    input  logic              audio_sdout,
    output logic              adc_mclk,
    output logic              adc_lrck,
    output logic              adc_sck,
    output logic [DATA_W-1:0] left_sample,
    output logic [DATA_W-1:0] right_sample,
    output logic              sample_valid,
    output logic              loud_pulse
);

    // Last bit slot that contributes to the kept sample.
    localparam logic [4:0]        LAST_SLOT = 5'(DATA_W);
    localparam logic [DATA_W-1:0] MOST_NEG  = DATA_W'(1) << (DATA_W - 1);
    localparam logic [DATA_W-1:0] MAX_POS   = ~MOST_NEG;
    localparam logic [7:0]        HOLD_LOAD = 8'(HOLDOFF);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [10:0]       cnt_q,      cnt_d;
    logic              sd_meta_q;
    logic              sd_sync_q;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [DATA_W-1:0] shadow_q,   shadow_d;
    logic [DATA_W-1:0] left_q,     left_d;
    logic [DATA_W-1:0] right_q,    right_d;
    logic              valid_q,    valid_d;
    logic              loud_q,     loud_d;
    logic              frame_en_q, frame_en_d;
    logic [7:0]        hold_q,     hold_d;

    // ---------------------------------------------------------------------
    // Decode of the counter
    // ---------------------------------------------------------------------
    logic              strobe;
    logic [4:0]        slot;
    logic              is_right;
    logic              bit_slot;
    logic              last_slot;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mag;
    logic              loud_hit;

    // The strobe is the cycle at which sck is about to rise; data has been
    // stable for half a bit period by then, even after the synchronizer.
    assign strobe    = (cnt_q[4:0] == 5'd15);
    assign slot      = cnt_q[9:5];
    assign is_right  = cnt_q[10];
    // Slot 0 carries the I2S one-bit delay; slots past DATA_W are the
    // truncated low bits of the ADC word.
    assign bit_slot  = strobe && (slot != 5'd0) && (slot <= LAST_SLOT);
    assign last_slot = strobe && (slot == LAST_SLOT);
    assign shifted   = (shift_q << 1) | DATA_W'(sd_sync_q);

    // Magnitude of the left sample being delivered. Negating the most
    // negative code would wrap back to itself, so it saturates instead.
    always_comb begin
        mag = shadow_q;
        if (shadow_q == MOST_NEG) begin
            mag = MAX_POS;
        end else if (shadow_q[DATA_W-1]) begin
            mag = ~shadow_q + DATA_W'(1);
        end
    end

    assign loud_hit = (mag >= THRESHOLD);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q + 11'd1;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = 1'b0;
        loud_d     = 1'b0;
        hold_d     = hold_q;
        frame_en_d = frame_en_q;

        // Sampled on the cycle before the counter wraps so that the new
        // value governs the frame starting at cnt == 0. Right after reset
        // the counter sits at 0 without wrapping, so the first frame after
        // release is never enabled.
        if (cnt_q == 11'h7FF) begin
            frame_en_d = en_capture;
        end

        if (bit_slot) begin
            shift_d = shifted;
        end

        if (last_slot && !is_right) begin
            shadow_d = shifted;
        end

        if (last_slot && is_right && frame_en_q) begin
            left_d  = shadow_q;
            right_d = shifted;
            valid_d = 1'b1;
            if (loud_hit && (hold_q == 8'd0)) begin
                loud_d = 1'b1;
                hold_d = HOLD_LOAD;
            end else if (hold_q != 8'd0) begin
                hold_d = hold_q - 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            sd_meta_q  <= 1'b0;
            sd_sync_q  <= 1'b0;
            shift_q    <= '0;
            shadow_q   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            loud_q     <= 1'b0;
            hold_q     <= '0;
            frame_en_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sd_meta_q  <= audio_sdout;
            sd_sync_q  <= sd_meta_q;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            loud_q     <= loud_d;
            hold_q     <= hold_d;
            frame_en_q <= frame_en_d;
        end
    end

    // Clocks come straight from counter flops, so they are glitch-free.
    assign adc_mclk     = cnt_q[1];
    assign adc_sck      = cnt_q[4];
    assign adc_lrck     = cnt_q[10];
    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign loud_pulse   = loud_q;

endmodule

// File: tb/tb_audio_capture.sv
// -----------------------------------------------------------------------------
// tb_audio_capture
//
// Directed bench for audio_capture. An ADC model reacts to the DUT's bit and
// word clocks like the real converter: MSB one sck after each word-select
// change, bits changing on the falling edge of sck. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_audio_capture;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              en_capture;
    logic              audio_sdout;
    logic              adc_mclk;
    logic              adc_lrck;
    logic              adc_sck;
    logic [DATA_W-1:0] left_sample;
    logic [DATA_W-1:0] right_sample;
    logic              sample_valid;
    logic              loud_pulse;

    // Words the ADC model transmits every frame.
    logic [23:0] left_word;
    logic [23:0] right_word;

    int n_cmp;
    int n_err;

    audio_capture #(
        .DATA_W   (DATA_W),
        .THRESHOLD(16'd20000),
        .HOLDOFF  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_capture  (en_capture),
        .audio_sdout (audio_sdout),
        .adc_mclk    (adc_mclk),
        .adc_lrck    (adc_lrck),
        .adc_sck     (adc_sck),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .loud_pulse  (loud_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model.
    initial begin
        int   idx;
        logic last_lrck;
        logic [23:0] word;
        idx         = 0;
        last_lrck   = 1'b0;
        audio_sdout = 1'b0;
        forever begin
            @(negedge adc_sck or negedge rst);
            #1;
            if (!rst) begin
                idx         = 0;
                last_lrck   = 1'b0;
                audio_sdout = 1'b0;
            end else begin
                if (adc_lrck != last_lrck) begin
                    idx       = 0;
                    last_lrck = adc_lrck;
                end else begin
                    idx = idx + 1;
                end
                word = adc_lrck ? right_word : left_word;
                audio_sdout = (idx >= 1 && idx <= 24) ? word[24 - idx] : 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts clk edges until sample_valid is seen; returns the bound if it
    // never comes, which then fails the caller's gap comparison.
    task automatic wait_valid(input int max_cyc, output int waited);
        waited = max_cyc;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (sample_valid) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, " left"},  32'(left_sample),  32'h0);
        check_eq({tag, " right"}, 32'(right_sample), 32'h0);
        check_eq({tag, " valid"}, 32'(sample_valid), 32'h0);
        check_eq({tag, " loud"},  32'(loud_pulse),   32'h0);
        check_eq({tag, " clks"},  32'({adc_mclk, adc_sck, adc_lrck}), 32'h0);
    endtask

    // Leaves rst released just after a clk edge, so the next edge is cnt=1.
    task automatic do_reset();
        rst = 1'b0;
        repeat (4) step();
        rst = 1'b1;
    endtask

    initial begin
        int          gap;
        int          nvalid;
        logic [15:0] th_val [6];
        logic        th_exp [6];
        logic        ho_exp [6];
        logic [10:0] k;

        th_val = '{16'hB1E0, 16'hB1E1, 16'h8000, 16'h7FFF, 16'h4E20, 16'h4E1F};
        th_exp = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
        ho_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        en_capture = 1'b1;
        left_word  = 24'hA5C3F1;
        right_word = 24'h123456;

        // Reset state.
        repeat (3) step();
        check_zero_outputs("reset");
        rst = 1'b1;

        // Clock dividers over the first frame, then first capture.
        for (int i = 1; i <= 2047; i++) begin
            step();
            k = 11'(i);
            if (i inside {1, 2, 3, 4, 5, 15, 16, 31, 32, 1023, 1024, 2047}) begin
                check_eq($sformatf("clk@%0d", i),
                         32'({adc_mclk, adc_sck, adc_lrck}),
                         32'({k[1], k[4], k[10]}));
            end
            if (sample_valid) begin
                check_eq($sformatf("early valid@%0d", i), 32'(sample_valid), 32'h0);
            end
        end
        wait_valid(4000, gap);
        check_eq("first valid gap", 32'(gap + 2047), 32'd3600);
        check_eq("cap left",  32'(left_sample),  32'hA5C3);
        check_eq("cap right", 32'(right_sample), 32'h1234);
        check_eq("cap loud",  32'(loud_pulse),   32'h1);
        step();
        check_eq("valid one cycle", 32'(sample_valid), 32'h0);
        check_eq("loud one cycle",  32'(loud_pulse),   32'h0);
        wait_valid(4000, gap);
        check_eq("period", 32'(gap), 32'd2047);
        check_eq("cap2 left", 32'(left_sample), 32'hA5C3);
        check_eq("cap2 loud (holdoff)", 32'(loud_pulse), 32'h0);

        // Threshold edges, each from a cleared holdoff counter.
        for (int i = 0; i < 6; i++) begin
            left_word = {th_val[i], 8'h5A};
            do_reset();
            wait_valid(4000, gap);
            check_eq($sformatf("th %h gap", th_val[i]), 32'(gap), 32'd3600);
            check_eq($sformatf("th %h left", th_val[i]), 32'(left_sample), 32'(th_val[i]));
            check_eq($sformatf("th %h loud", th_val[i]), 32'(loud_pulse), 32'(th_exp[i]));
        end

        // Holdoff of 4 frames.
        left_word = 24'h900000;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            wait_valid(4000, gap);
            check_eq($sformatf("holdoff f%0d gap", f + 1), 32'(gap), (f == 0) ? 32'd3600 : 32'd2048);
            check_eq($sformatf("holdoff f%0d loud", f + 1), 32'(loud_pulse), 32'(ho_exp[f]));
        end

        // Enable: drop mid-frame, raise mid-frame two frames later.
        en_capture = 1'b0;
        left_word  = 24'hA00000;
        nvalid     = 0;
        for (int i = 0; i < 4096; i++) begin
            step();
            if (sample_valid) nvalid = nvalid + 1;
        end
        check_eq("disabled valids", 32'(nvalid), 32'd0);
        check_eq("disabled left hold",  32'(left_sample),  32'h9000);
        check_eq("disabled right hold", 32'(right_sample), 32'h1234);
        en_capture = 1'b1;
        wait_valid(4000, gap);
        check_eq("resume gap", 32'(gap), 32'd2048);
        check_eq("resume left", 32'(left_sample), 32'hA000);
        check_eq("resume loud (holdoff)", 32'(loud_pulse), 32'h0);

        // Reset mid-frame at cnt = 1000.
        repeat (2048 - 1552 + 1000) step();
        rst = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) step();
        rst = 1'b1;
        wait_valid(4000, gap);
        check_eq("post-reset gap", 32'(gap), 32'd3600);
        check_eq("post-reset left", 32'(left_sample), 32'hA000);
        check_eq("post-reset loud", 32'(loud_pulse), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_capture.md
# audio_capture

I2S receive path for the Pmod I2S2 ADC (line-in) side, the counterpart of the existing DAC playback path. It generates the ADC master, word and bit clocks from the system clock, deserializes the ADC's serial data into signed left/right sample pairs, and raises a one-cycle pulse when the left channel exceeds a loudness threshold. This lets the game accept a clap or knock as a hit source.

## Interface

- DATA_W, 16: bits kept per channel, taken MSB-first from the 24-bit ADC word; legal range 1..24.
- THRESHOLD, 16'd20000: unsigned magnitude at or above which a loud event fires; width DATA_W.
- HOLDOFF, 8: frames after a loud event during which further loud events are suppressed; legal range 0..255.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- en_capture  in  1  capture enable, sampled at frame start.
- audio_sdout  in  1  ADC serial data, driven by the ADC on the falling edge of sck.
- adc_mclk  out  1  ADC master clock, clk/4.
- adc_lrck  out  1  word select, clk/2048; 0 = left, 1 = right.
- adc_sck  out  1  bit clock, clk/32; 32 sck per channel.
- left_sample  out  DATA_W  last complete left sample, two's complement.
- right_sample  out  DATA_W  last complete right sample, two's complement.
- sample_valid  out  1  one-cycle pulse when both samples update.
- loud_pulse  out  1  one-cycle pulse coincident with sample_valid.

## Operation

- Clock generation:
  - An 11-bit free-running counter cnt increments every clk.
  - adc_mclk = cnt[1], adc_sck = cnt[4], adc_lrck = cnt[10]. All three are driven directly from registered counter bits.
  - slot = cnt[9:5] (0..31) is the bit slot within the current channel.
- Input sync: audio_sdout passes through a 2-flop synchronizer. The 20 ns delay sits well inside the 160 ns stable window.
- Strobe:
  - The strobe is the clk cycle with cnt[4:0] == 15, i.e. the edge where sck rises.
  - On a strobe with slot in 1..DATA_W, the synchronized bit shifts into a DATA_W shift register, MSB first. Slot 0 is the I2S one-bit delay and is ignored.
  - Slots above DATA_W are ignored, which truncates the low ADC bits.
- Frame handling:
  - Left strobe with slot == DATA_W: the shift register copies into a left shadow register.
  - Right strobe with slot == DATA_W, with the frame enabled: left_sample ← shadow, right_sample ← shift register, sample_valid = 1 for the next cycle only.
- Enable:
  - frame_en is latched from en_capture at cnt == 0.
  - When frame_en = 0: no output update, no sample_valid, no loud_pulse, and the holdoff counter is frozen.
  - The clocks run regardless of enable.
- Loud detector:
  - mag = |left| computed from the newly completed left sample. The most-negative code saturates to 2^(DATA_W-1)−1.
  - Fire condition: mag ≥ THRESHOLD and holdoff counter == 0. Then loud_pulse asserts in the same cycle as sample_valid, and the counter loads HOLDOFF.
  - Otherwise a nonzero counter decrements by 1 per sample_valid.

## Timing

- Reset values:
  - cnt = 0, so adc_mclk, adc_sck and adc_lrck are all 0.
  - left_sample = right_sample = 0; sample_valid = loud_pulse = 0.
  - Shadow register, shift register and holdoff counter = 0; frame_en = 0.
- Latency:
  - Right-channel strobe occurs at cnt = 1024 + 32·DATA_W + 15 (1551 for DATA_W = 16).
  - sample_valid and updated samples appear in the following cycle (cnt = 1552).
  - Period thereafter is exactly 2048 clk.
- Enable after reset: frame_en = 0 until the first cnt == 0 after the counter wraps. The first sample_valid is therefore at cycle 2048 + 1552 after reset release, provided en_capture is high at cnt == 0.
- Enable changes mid-frame have no effect until the next cnt == 0. A frame in progress is never partially delivered.
- Reset mid-frame: everything returns immediately to reset values and the partial frame is discarded. Clocks restart from cnt = 0 with sck, lrck and mclk low.
- sample_valid and loud_pulse are never high for two consecutive cycles.

## Test plan

- Reset/clocks: hold rst = 0, then release. Required: all outputs 0 during reset; adc_mclk period 4 clk, adc_sck period 32 clk, adc_lrck period 2048 clk, all starting low.
- Capture: bench ADC model drives left = 24'hA5C3F1, right = 24'h123456 every frame, with en_capture = 1. Required: first sample_valid 3600 clk after release; left_sample = 16'hA5C3, right_sample = 16'h1234; subsequent pulses every 2048 clk.
- Threshold edges:
  - Left = 16'hB1E0 (−20000): loud_pulse fires.
  - Left = 16'hB1E1 (−19999): no pulse.
  - Left = 16'h8000: pulse, with mag saturated to 32767.
  - Left = 16'h7FFF: pulse.
  - Each case starts from a cleared holdoff counter.
- Holdoff: left = 16'h9000 on every frame, HOLDOFF = 4. Required: loud_pulse on frame 1, none on frames 2–5, pulse again on frame 6.
- Enable: drop en_capture mid-frame, then raise it mid-frame two frames later. Required: no sample_valid for the frames following the drop; outputs hold their old values; delivery resumes only at the first frame starting after the rise.
- Reset mid-frame: assert rst at cnt = 1000. Required: immediate zero outputs and no sample_valid until 3600 clk after release.
